// File: rtl/hh_pkg.sv
// Shared constants for the Hodgkin-Huxley gating engine: gate encodings,
// fixed-point unity, gate reset values and FSM state codes.
package hh_pkg;

    localparam logic [1:0] GATE_M = 2'd0;
    localparam logic [1:0] GATE_H = 2'd1;
    localparam logic [1:0] GATE_N = 2'd2;

    localparam int unsigned FRAC_BITS = 12;
    localparam int unsigned ONE       = 1 << FRAC_BITS;

    // Resting-state gates: 0.053, 0.596, 0.318 in Q12
    localparam int unsigned M0 = 217;
    localparam int unsigned H0 = 2441;
    localparam int unsigned N0 = 1302;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_CALC   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/hh_gate_engine_if.sv
// Request, rate-table configuration and response signals of the gating engine.
interface hh_gate_engine_if #(
    parameter int unsigned W      = 16,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned LUT_AW = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch;
    logic [W-1:0]      req_v;
    logic [W-1:0]      req_dt;

    logic              cfg_we;
    logic [1:0]        cfg_gate;
    logic              cfg_sel;
    logic [LUT_AW-1:0] cfg_addr;
    logic [W-1:0]      cfg_data;
    logic              cfg_err;

    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [W-1:0]      out_m;
    logic [W-1:0]      out_h;
    logic [W-1:0]      out_n;

    modport master (
        output req_valid, req_ch, req_v, req_dt,
        output cfg_we, cfg_gate, cfg_sel, cfg_addr, cfg_data,
        output out_ready,
        input  req_ready, cfg_err, out_valid, out_ch, out_m, out_h, out_n
    );

    modport slave (
        input  req_valid, req_ch, req_v, req_dt,
        input  cfg_we, cfg_gate, cfg_sel, cfg_addr, cfg_data,
        input  out_ready,
        output req_ready, cfg_err, out_valid, out_ch, out_m, out_h, out_n
    );
endinterface

// File: rtl/hh_euler_step.sv
// One forward-Euler step of a gating variable:
// x' = sat(x + floor((alpha*(1-x) - beta*x) * max(dt,0)), 0, 1).
module hh_euler_step #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 12
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] alpha_i,
    input  logic [W-1:0] beta_i,
    input  logic [W-1:0] dt_i,
    output logic [W-1:0] x_o
);
    localparam int unsigned DW = 2*W + 4;
    localparam int unsigned PW = 3*W + 4;
    localparam logic signed [DW-1:0] ONE_D = DW'(1 << FRAC);
    localparam logic signed [PW-1:0] ONE_P = PW'(1 << FRAC);

    logic signed [DW-1:0] x_s, a_s, b_s, omx_s, d_s;
    logic signed [PW-1:0] d_p, dte_s, prod_s, delta_s, sum_s;

    always_comb begin
        x_s     = $signed({{(DW-W){1'b0}}, x_i});
        a_s     = $signed({{(DW-W){1'b0}}, alpha_i});
        b_s     = $signed({{(DW-W){1'b0}}, beta_i});
        omx_s   = ONE_D - x_s;
        d_s     = a_s * omx_s - b_s * x_s;
        d_p     = $signed({{(PW-DW){d_s[DW-1]}}, d_s});
        dte_s   = dt_i[W-1] ? '0 : $signed({{(PW-W){1'b0}}, dt_i});
        prod_s  = d_p * dte_s;
        // Arithmetic shift gives floor for negative products
        delta_s = prod_s >>> (2*FRAC);
        sum_s   = $signed({{(PW-W){1'b0}}, x_i}) + delta_s;
        if (sum_s < 0)
            x_o = '0;
        else if (sum_s > ONE_P)
            x_o = W'(ONE_P);
        else
            x_o = sum_s[W-1:0];
    end
endmodule

// File: rtl/hh_gate_engine.sv
// Time-multiplexed m/h/n gate updater for N_CH neurons; one Euler datapath
// is shared by all gates and channels, sequenced by a small FSM.
module hh_gate_engine
    import hh_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned FRAC    = 12,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned LUT_AW  = 4,
    parameter int          V_MIN   = -100,
    parameter int unsigned V_SHIFT = 3
) (
    input  logic             clk,
    input  logic             reset,
    hh_gate_engine_if.slave  bus
);
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DEPTH = 1 << LUT_AW;
    localparam int unsigned VW    = W + 2;
    localparam logic signed [VW-1:0] VMIN_S  = VW'(V_MIN);
    localparam logic signed [VW-1:0] IDX_MAX = VW'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        gate_q, gate_d;
    logic [CH_W-1:0]   ch_q;
    logic [W-1:0]      v_q, dt_q;
    logic [W-1:0]      alpha_q, beta_q, x_q, xn_q, xn;
    logic [W-1:0]      st_q [N_CH][3];
    logic [W-1:0]      alpha_tab_q [3][DEPTH];
    logic [W-1:0]      beta_tab_q  [3][DEPTH];
    logic              out_valid_q, cfg_err_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [W-1:0]      out_m_q, out_h_q, out_n_q;

    logic              ch_ok, cfg_ok, cfg_reject;
    logic signed [VW-1:0] vdiff, vsh;
    logic [LUT_AW-1:0] idx;

    always_comb begin
        ch_ok      = 32'(ch_q) < N_CH;
        cfg_ok     = bus.cfg_we && (state_q == ST_IDLE) && (bus.cfg_gate != 2'd3);
        cfg_reject = bus.cfg_we && !cfg_ok;
        vdiff      = $signed({{2{v_q[W-1]}}, v_q}) - VMIN_S;
        vsh        = vdiff >>> V_SHIFT;
        if (vsh < 0)
            idx = '0;
        else if (vsh > IDX_MAX)
            idx = '1;
        else
            idx = vsh[LUT_AW-1:0];
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) begin
                           state_d = ST_LOOKUP;
                           gate_d  = GATE_M;
                       end
            ST_LOOKUP: state_d = ST_CALC;
            ST_CALC:   state_d = ST_WRITE;
            ST_WRITE:  if (gate_q < GATE_N) begin
                           gate_d  = gate_q + 2'd1;
                           state_d = ST_LOOKUP;
                       end else begin
                           state_d = ST_RESP;
                       end
            ST_RESP:   if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    hh_euler_step #(.W(W), .FRAC(FRAC)) u_step (
        .x_i     (x_q),
        .alpha_i (alpha_q),
        .beta_i  (beta_q),
        .dt_i    (dt_q),
        .x_o     (xn)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gate_q      <= GATE_M;
            ch_q        <= '0;
            v_q         <= '0;
            dt_q        <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            x_q         <= '0;
            xn_q        <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_ch_q    <= '0;
            out_m_q     <= '0;
            out_h_q     <= '0;
            out_n_q     <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                st_q[c][GATE_M] <= W'(M0);
                st_q[c][GATE_H] <= W'(H0);
                st_q[c][GATE_N] <= W'(N0);
            end
            for (int unsigned g = 0; g < 3; g++) begin
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    alpha_tab_q[g][a] <= '0;
                    beta_tab_q[g][a]  <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            cfg_err_q <= cfg_reject;
            if (cfg_ok) begin
                if (bus.cfg_sel)
                    beta_tab_q[bus.cfg_gate][bus.cfg_addr]  <= bus.cfg_data;
                else
                    alpha_tab_q[bus.cfg_gate][bus.cfg_addr] <= bus.cfg_data;
            end
            case (state_q)
                ST_IDLE: if (bus.req_valid) begin
                    ch_q <= bus.req_ch;
                    v_q  <= bus.req_v;
                    dt_q <= bus.req_dt;
                end
                ST_LOOKUP: begin
                    alpha_q <= alpha_tab_q[gate_q][idx];
                    beta_q  <= beta_tab_q[gate_q][idx];
                    x_q     <= ch_ok ? st_q[ch_q][gate_q] : '0;
                end
                ST_CALC:  xn_q <= xn;
                ST_WRITE: if (ch_ok) st_q[ch_q][gate_q] <= xn_q;
                ST_RESP: begin
                    // First RESP cycle loads the result registers; out_valid follows them
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_ch_q    <= ch_q;
                        out_m_q     <= ch_ok ? st_q[ch_q][GATE_M] : '0;
                        out_h_q     <= ch_ok ? st_q[ch_q][GATE_H] : '0;
                        out_n_q     <= ch_ok ? st_q[ch_q][GATE_N] : '0;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_m     = out_m_q;
    assign bus.out_h     = out_h_q;
    assign bus.out_n     = out_n_q;
endmodule

// File: tb/tb_hh_gate_engine.sv
// Directed bench for hh_gate_engine: a vector table of table writes and
// steps with hand-computed gates, then busy-write, stall and reset sequences.
module tb_hh_gate_engine;
    import hh_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hh_gate_engine_if #(.W(16), .CH_W(2), .LUT_AW(4)) bus ();

    hh_gate_engine #(
        .W(16), .FRAC(12), .N_CH(4), .LUT_AW(4), .V_MIN(-100), .V_SHIFT(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit                 do_cfg;
        logic [1:0]         g;
        logic               sel;
        logic [3:0]         a;
        logic [15:0]        d;
        logic               exp_err;
        bit                 do_step;
        logic [1:0]         ch;
        logic signed [15:0] v;
        logic signed [15:0] dt;
        logic [15:0]        em;
        logic [15:0]        eh;
        logic [15:0]        en;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_ch    = '0;
        bus.req_v     = '0;
        bus.req_dt    = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_gate  = '0;
        bus.cfg_sel   = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] g, input logic sel, input logic [3:0] a,
                             input logic [15:0] d, input logic exp_err);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_gate = g;
        bus.cfg_sel  = sel;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        check("cfg_err", bus.cfg_err, exp_err);
    endtask

    task automatic accept_req(input logic [1:0] ch, input logic [15:0] v, input logic [15:0] dt);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_ch    = ch;
        bus.req_v     = v;
        bus.req_dt    = dt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("req_ready_busy", bus.req_ready, 0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_resp(input logic [1:0] ch, input logic [15:0] em,
                             input logic [15:0] eh, input logic [15:0] en);
        check("out_valid", bus.out_valid, 1);
        check("out_ch", bus.out_ch, ch);
        check("out_m", bus.out_m, em);
        check("out_h", bus.out_h, eh);
        check("out_n", bus.out_n, en);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
        check("req_ready_back", bus.req_ready, 1);
    endtask

    task automatic run_step(input logic [1:0] ch, input logic [15:0] v, input logic [15:0] dt,
                            input logic [15:0] em, input logic [15:0] eh, input logic [15:0] en);
        int lat;
        accept_req(ch, v, dt);
        wait_valid(lat);
        check("latency", lat, 10);
        take_resp(ch, em, eh, en);
    endtask

    initial begin
        int lat;

        //          cfg  g  sel a    data   err  step ch  V       dt       m     h     n
        vt[0]  = '{0, 0, 0, 0,  0,     0,   1, 0,  -16'sd65,  16'sd410,  217,  2441, 1302};
        vt[1]  = '{1, 0, 0, 4,  4096,  0,   0, 0,  16'sd0,    16'sd0,    0,    0,    0};
        vt[2]  = '{1, 0, 1, 4,  0,     0,   1, 0,  -16'sd65,  16'sd410,  605,  2441, 1302};
        vt[3]  = '{1, 0, 0, 4,  65535, 0,   1, 0,  -16'sd65,  16'sd4095, ONE,  2441, 1302};
        vt[4]  = '{1, 0, 0, 4,  0,     0,   0, 0,  16'sd0,    16'sd0,    0,    0,    0};
        vt[5]  = '{1, 0, 1, 4,  65535, 0,   1, 0,  -16'sd65,  16'sd4095, 0,    2441, 1302};
        vt[6]  = '{1, 0, 0, 0,  4096,  0,   1, 1,  -16'sd200, 16'sd410,  605,  2441, 1302};
        vt[7]  = '{0, 0, 0, 0,  0,     0,   1, 2,  -16'sd100, 16'sd410,  605,  2441, 1302};
        vt[8]  = '{1, 2, 0, 15, 4096,  0,   1, 1,  16'sd500,  16'sd410,  605,  2441, 1581};
        vt[9]  = '{0, 0, 0, 0,  0,     0,   1, 2,  16'sd27,   16'sd410,  605,  2441, 1581};
        vt[10] = '{0, 0, 0, 0,  0,     0,   1, 1,  -16'sd200, -16'sd410, 605,  2441, 1581};
        vt[11] = '{0, 0, 0, 0,  0,     0,   1, 0,  16'sd0,    16'sd410,  0,    2441, 1302};
        vt[12] = '{1, 3, 0, 12, 4096,  1,   0, 0,  16'sd0,    16'sd0,    0,    0,    0};
        vt[13] = '{0, 0, 0, 0,  0,     0,   1, 0,  16'sd0,    16'sd410,  0,    2441, 1302};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_out_m", bus.out_m, 0);
        check("rst_out_h", bus.out_h, 0);
        check("rst_out_n", bus.out_n, 0);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].do_cfg) cfg_write(vt[i].g, vt[i].sel, vt[i].a, vt[i].d, vt[i].exp_err);
            if (vt[i].do_step) run_step(vt[i].ch, vt[i].v, vt[i].dt, vt[i].em, vt[i].eh, vt[i].en);
        end

        // Write attempted while busy, then a held response
        accept_req(2'd0, 16'sd0, 16'sd410);
        @(negedge clk);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_gate = 2'd0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_addr = 4'd12;
        bus.cfg_data = 16'd4096;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        check("cfg_err_busy", bus.cfg_err, 1);
        @(posedge clk);
        #1;
        check("cfg_err_pulse_end", bus.cfg_err, 0);
        wait_valid(lat);
        check("busy_latency", lat, 7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_m", bus.out_m, 0);
            check("stall_h", bus.out_h, 2441);
            check("stall_n", bus.out_n, 1302);
        end
        take_resp(2'd0, 16'd0, 16'd2441, 16'd1302);
        run_step(2'd0, 16'sd0, 16'sd410, 16'd0, 16'd2441, 16'd1302);

        // Reset during the CALC of the second gate
        accept_req(2'd0, -16'sd65, 16'sd410);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_req_ready", bus.req_ready, 1);
        check("postrst_out_valid", bus.out_valid, 0);
        check("postrst_out_m", bus.out_m, 0);
        run_step(2'd0, -16'sd65, 16'sd410, 16'd217, 16'd2441, 16'd1302);
        run_step(2'd1, -16'sd200, 16'sd410, 16'd217, 16'd2441, 16'd1302);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
